irq_sequencer: RTL

- Interrupt front-end for the single-cycle LEGv8 core.
- Collects N external interrupt lines and detects rising edges into pending bits.
- Applies a software mask and fixed priority, and drives the core's single ExtIRQ line.
- Completes the ExtIRQ/ExtlAck handshake with the controller, then holds the in-service state until the handler's ERET retires it.

---
 rtl/irq_sequencer.sv | 82 ++++++++
 1 files changed

// File: rtl/irq_sequencer.sv
// irq_sequencer: edge-detecting, masked, fixed-priority interrupt front-end with ExtIRQ/ExtlAck/ERET handshake.
// Define IRQ_DROPCNT_EN to build the saturating lost-edge counter on drop_cnt.
module irq_sequencer #(
  parameter int N_IRQ = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             ExtlAck,
  input  logic             ERet,
  output logic             ExtIRQ,
  output logic [ID_W-1:0]  irq_id,
  output logic             in_service,
  output logic [N_IRQ-1:0] pending_o,
  output logic [N_IRQ-1:0] mask_o,
  output logic             spurious_eret,
  output logic [7:0]       drop_cnt
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE, RETIRE} state_t;
  state_t state, state_nx;
  logic [N_IRQ-1:0] pending, irq_prev, mask, rise, eligible, clr;
  logic [ID_W-1:0] winner;
  logic ack;
  assign rise     = irq_i & ~irq_prev;
  assign eligible = pending & mask;
  assign ack      = state == REQ && ExtlAck;
  assign clr      = ack ? N_IRQ'(1) << irq_id : '0;
  // scanning downward leaves the lowest eligible index as the winner
  always_comb begin
    winner = '0;
    for (int k = N_IRQ - 1; k >= 0; k--)
      if (eligible[k]) winner = ID_W'(k);
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = |eligible ? REQ : IDLE;
      REQ:     state_nx = ExtlAck ? SERVICE : REQ;
      SERVICE: state_nx = ERet ? RETIRE : SERVICE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      pending       <= '0;
      irq_prev      <= '0;
      mask          <= '1;
      irq_id        <= '0;
      spurious_eret <= 1'b0;
    end else begin
      state         <= state_nx;
      pending       <= (pending & ~clr) | rise;
      irq_prev      <= irq_i;
      mask          <= mask_we ? mask_wdata : mask;
      irq_id        <= (state == IDLE && |eligible) ? winner : irq_id;
      spurious_eret <= spurious_eret | (ERet && state != SERVICE);
    end
  end
  assign ExtIRQ     = state == REQ;
  assign in_service = state == SERVICE;
  assign pending_o  = pending;
  assign mask_o     = mask;
`ifdef IRQ_DROPCNT_EN
  logic [N_IRQ-1:0] lost;
  logic [8:0] sum;
  assign lost = rise & pending & ~clr;
  always_comb begin
    sum = {1'b0, drop_cnt};
    for (int k = 0; k < N_IRQ; k++) sum = sum + 9'(lost[k]);
  end
  always_ff @(posedge clk) begin
    if (!reset) drop_cnt <= 8'h00;
    else drop_cnt <= sum[8] ? 8'hFF : sum[7:0];
  end
`else
  assign drop_cnt = 8'h00;
`endif
endmodule
